ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/ram_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-port RAM arbiter: default address width,
// data width and the port-ID encoding used by the last-grant register.
package ram_arbiter_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 12;
    localparam int DATA_WIDTH            = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a fixed-priority override for port B.
// Grants are combinational; only the last-granted port is registered.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic prio_b,
    output logic gnt_a,
    output logic gnt_b
);

    port_e last_grant;

    always_comb begin
        // NOTE: every output gets a default before any branch so no path can infer a latch.
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (prio_b) begin
                gnt_b = req_b;
                gnt_a = req_a & ~req_b;
            end else if (req_a && req_b) begin
                gnt_a = (last_grant == PORT_B);
                gnt_b = (last_grant == PORT_A);
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // Reset to B so A wins the first contended round-robin cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst)        last_grant <= PORT_B;
        else if (gnt_a) last_grant <= PORT_A;
        else if (gnt_b) last_grant <= PORT_B;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port (A) and a PPU/DMA port (B) onto one single-port RAM
// with registered read data; one access per cycle, no bubbles.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prio_b,

    input  logic                     a_req,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic                     a_wr_en,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,

    input  logic                     b_req,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic                     b_wr_en,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    b_rdata,

    output logic                     ram_en,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_wr_en,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out
);

    logic a_rvalid_q;
    logic b_rvalid_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_a  (a_req),
        .req_b  (b_req),
        .prio_b (prio_b),
        .gnt_a  (a_gnt),
        .gnt_b  (b_gnt)
    );

    // Idle cycles drive zeros so the RAM bus is quiet and deterministic.
    always_comb begin
        ram_en      = a_gnt | b_gnt;
        ram_addr    = '0;
        ram_wr_en   = 1'b0;
        ram_data_in = '0;
        if (a_gnt) begin
            ram_addr    = a_addr;
            ram_wr_en   = a_wr_en;
            ram_data_in = a_wdata;
        end else if (b_gnt) begin
            ram_addr    = b_addr;
            ram_wr_en   = b_wr_en;
            ram_data_in = b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_gnt & ~a_wr_en;
            b_rvalid_q <= b_gnt & ~b_wr_en;
        end
    end

    // Masking with rst also kills a read returning in the very cycle reset rises.
    assign a_rvalid = a_rvalid_q & ~rst;
    assign b_rvalid = b_rvalid_q & ~rst;
    assign a_rdata  = ram_data_out;
    assign b_rdata  = ram_data_out;

endmodule
